// File: rtl/spd_info_frame_receiver.sv
// SPD InfoFrame receiver: filters SPD packets, checks the header, sums the checksum one byte per cycle
// and latches vendor/product/source-device fields from frames whose checksum is good.
module spd_info_frame_receiver #(
    parameter logic ZERO_TO_ASCII = 1'b1
) (
    input  logic              clk_pixel,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [23:0]       header,
    input  logic [3:0][55:0]  sub,
    output logic [63:0]       vendor_name,
    output logic [127:0]      product_description,
    output logic [7:0]        source_device_information,
    output logic              spd_valid,
    output logic              checksum_error,
    output logic              header_error
);

    typedef enum logic [1:0] {IDLE, SUM, DONE, HERR} state_t;

    state_t           state;
    state_t           next_state;
    logic [3:0][55:0] payload;
    logic [7:0]       acc;
    logic [4:0]       idx;
    logic [7:0]       pb [0:27];
    logic [7:0]       running_sum;
    logic             handshake;
    logic             is_spd;
    logic             header_ok;
    logic             last_byte;

    function automatic logic [7:0] map_byte(input logic [7:0] b);
        return (ZERO_TO_ASCII && b == 8'h00) ? 8'h30 : b;
    endfunction

    // Flat view of the captured payload: PB(7i+k) lives in subpacket i, byte k.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 7; k++) begin
                pb[7*i+k] = payload[i][8*k +: 8];
            end
        end
    end

    assign in_ready    = (state == IDLE);
    assign handshake   = in_valid && in_ready;
    assign is_spd      = (header[7:0] == 8'h83);
    assign header_ok   = (header[15:8] == 8'h01) && (header[20:16] == 5'd25);
    assign last_byte   = (state == SUM) && (idx == 5'd25);
    assign running_sum = acc + pb[idx];

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (handshake && is_spd) next_state = header_ok ? SUM : HERR;
            SUM:  if (idx == 5'd25) next_state = DONE;
            DONE: next_state = IDLE;
            HERR: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The verdict is registered on the last SUM edge so pulse and new outputs appear together in DONE.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state                     <= IDLE;
            payload                   <= '0;
            acc                       <= 8'h00;
            idx                       <= 5'd0;
            vendor_name               <= 64'h0;
            product_description       <= 128'h0;
            source_device_information <= 8'h00;
            spd_valid                 <= 1'b0;
            checksum_error            <= 1'b0;
            header_error              <= 1'b0;
        end else begin
            state          <= next_state;
            spd_valid      <= 1'b0;
            checksum_error <= 1'b0;
            header_error   <= 1'b0;
            if (handshake) begin
                payload      <= sub;
                acc          <= header[7:0] + header[15:8] + header[23:16];
                idx          <= 5'd0;
                header_error <= is_spd && !header_ok;
            end
            if (state == SUM) begin
                acc <= running_sum;
                idx <= idx + 5'd1;
            end
            if (last_byte) begin
                if (running_sum == 8'h00) begin
                    spd_valid <= 1'b1;
                    for (int j = 0; j < 8; j++) begin
                        vendor_name[63-8*j -: 8] <= map_byte(pb[1+j]);
                    end
                    for (int j = 0; j < 16; j++) begin
                        product_description[127-8*j -: 8] <= map_byte(pb[9+j]);
                    end
                    source_device_information <= pb[25];
                end else begin
                    checksum_error <= 1'b1;
                end
            end
        end
    end

endmodule
